q_argmax_select: RTL and testbench

Downstream of feed_forward in the DQN datapath. Consumes the NUMBER_OF_OUTPUT_NODE IEEE-754 single-precision Q-values that the output layer streams out, one per beat. Produces the greedy action (the argmax) and the maximum Q-value. An optional epsilon-greedy override uses an internal 16-bit LFSR. The chosen action feeds the environment/replay path; max Q feeds the target computation.

---
 rtl/q_argmax_select.sv | 201 ++++++++++++++++++++
 tb/tb_q_argmax_select.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/q_argmax_select.sv
// -----------------------------------------------------------------------------
// q_argmax_select
//
// Greedy / epsilon-greedy action selector for the DQN datapath. Collects the
// NUMBER_OF_OUTPUT_NODE single-precision Q-values streamed by the output layer
// (one per beat, node 0 first). It then reports the index of the largest value
// and the value itself. When exploration is enabled, a 16-bit Galois LFSR may
// replace the greedy action with a pseudo-random one.
//
// Ports
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   i_valid       i_data carries one Q-value this cycle
//   i_data        Q-value (IEEE-754 single precision)
//   i_explore_en  epsilon-greedy enable, sampled with the last beat
//   i_epsilon     exploration threshold, sampled with the last beat
//   o_ready       block accepts beats (IDLE / COLLECT)
//   o_valid       one-cycle pulse, result outputs valid
//   o_action      selected action index
//   o_max_q       largest Q-value of the decision (always the greedy value)
//   o_random      o_action came from exploration
// -----------------------------------------------------------------------------
module q_argmax_select #(
  parameter int                         DATA_WIDTH            = 32,
  parameter int                         NUMBER_OF_OUTPUT_NODE = 3,
  parameter int                         ACTION_WIDTH          = 2,
  parameter int                         EPSILON_WIDTH         = 16,
  parameter logic [EPSILON_WIDTH-1:0]   LFSR_SEED             = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_valid,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic                     i_explore_en,
  input  logic [EPSILON_WIDTH-1:0] i_epsilon,
  output logic                     o_ready,
  output logic                     o_valid,
  output logic [ACTION_WIDTH-1:0]  o_action,
  output logic [DATA_WIDTH-1:0]    o_max_q,
  output logic                     o_random
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] DECIDE  = 2'd2;
  localparam logic [1:0] OUT     = 2'd3;

  // Single-precision field layout: sign at the MSB, then exponent, then mantissa.
  localparam int MANT_W = 23;

  localparam logic [EPSILON_WIDTH-1:0] LFSR_MASK = EPSILON_WIDTH'(16'hB400);
  localparam logic [ACTION_WIDTH-1:0]  LAST_CNT  = ACTION_WIDTH'(NUMBER_OF_OUTPUT_NODE - 1);
  localparam logic [ACTION_WIDTH:0]    N_EXT     = (ACTION_WIDTH + 1)'(NUMBER_OF_OUTPUT_NODE);
  localparam bit                       SINGLE    = (NUMBER_OF_OUTPUT_NODE == 1);

  // ---------------------------------------------------------------------------
  // Sign-magnitude float ordering, no FP unit.
  // NaN sorts below everything, +0 == -0, infinities are ordinary extremes.
  // Returns 1 only when a is strictly greater than b.
  // ---------------------------------------------------------------------------
  function automatic logic is_nan(input logic [DATA_WIDTH-1:0] v);
    return (&v[DATA_WIDTH-2:MANT_W]) && (|v[MANT_W-1:0]);
  endfunction

  function automatic logic q_greater(input logic [DATA_WIDTH-1:0] a,
                                     input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH-2:0] a_mag;
    logic [DATA_WIDTH-2:0] b_mag;
    a_mag = a[DATA_WIDTH-2:0];
    b_mag = b[DATA_WIDTH-2:0];
    if (is_nan(a))                    return 1'b0;
    if (is_nan(b))                    return 1'b1;
    if (a_mag == '0 && b_mag == '0)   return 1'b0;  // signed zeros compare equal
    case ({a[DATA_WIDTH-1], b[DATA_WIDTH-1]})
      2'b01:   return 1'b1;                         // positive beats negative
      2'b10:   return 1'b0;
      2'b00:   return a_mag > b_mag;
      default: return a_mag < b_mag;                // both negative
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]               state;
  logic [1:0]               state_d;
  logic [ACTION_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0]    max_q;
  logic [ACTION_WIDTH-1:0]  max_idx;
  logic                     explore_en_q;
  logic [EPSILON_WIDTH-1:0] epsilon_q;
  logic [EPSILON_WIDTH-1:0] lfsr;

  // ---------------------------------------------------------------------------
  // Combinational helpers
  // ---------------------------------------------------------------------------
  logic                     accept;
  logic                     last_beat;
  logic                     in_greater;
  logic [EPSILON_WIDTH-1:0] lfsr_next;
  logic                     explore;
  logic [ACTION_WIDTH:0]    r_ext;
  logic [ACTION_WIDTH-1:0]  rand_idx;

  assign o_ready    = (state == IDLE) || (state == COLLECT);
  assign accept     = i_valid && o_ready;
  assign in_greater = q_greater(i_data, max_q);

  // The last beat is either beat 0 (single-node configuration) or the beat
  // that arrives while the counter points at node N-1.
  assign last_beat  = accept && (((state == IDLE) && SINGLE) ||
                                 ((state == COLLECT) && (cnt == LAST_CNT)));

  // Galois right-shift step; a nonzero seed never reaches the all-zero state.
  assign lfsr_next  = {1'b0, lfsr[EPSILON_WIDTH-1:1]} ^ (lfsr[0] ? LFSR_MASK : '0);
  assign explore    = explore_en_q && (lfsr_next < epsilon_q);

  // Fold the low LFSR bits into 0..N-1 with a single conditional subtract.
  assign r_ext      = {1'b0, lfsr_next[ACTION_WIDTH-1:0]};
  assign rand_idx   = (r_ext >= N_EXT) ? ACTION_WIDTH'(r_ext - N_EXT)
                                       : r_ext[ACTION_WIDTH-1:0];

  // NOTE: every output of a combinational block gets a default assignment
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (accept)    state_d = SINGLE ? DECIDE : COLLECT;
      COLLECT: if (last_beat) state_d = DECIDE;
      DECIDE:                 state_d = OUT;
      OUT:                    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control and collection datapath
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      max_q        <= '0;
      max_idx      <= '0;
      explore_en_q <= 1'b0;
      epsilon_q    <= '0;
      lfsr         <= LFSR_SEED;
    end else begin
      state <= state_d;

      if (accept) begin
        if (state == IDLE) begin
          // Beat 0 seeds the running maximum unconditionally, so an all-NaN
          // set still reports index 0 and its own beat 0 value.
          max_q   <= i_data;
          max_idx <= '0;
          cnt     <= ACTION_WIDTH'(1);
        end else begin
          cnt <= cnt + ACTION_WIDTH'(1);
          // Strictly greater only: ties keep the lower index.
          if (in_greater) begin
            max_q   <= i_data;
            max_idx <= cnt;
          end
        end
      end

      if (last_beat) begin
        explore_en_q <= i_explore_en;
        epsilon_q    <= i_epsilon;
      end

      if (state == DECIDE) begin
        lfsr <= lfsr_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: loaded on the DECIDE->OUT edge so they are presented
  // throughout OUT, and held until the next decision.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_valid  <= 1'b0;
      o_action <= '0;
      o_max_q  <= '0;
      o_random <= 1'b0;
    end else begin
      o_valid <= (state == DECIDE);
      if (state == DECIDE) begin
        o_action <= explore ? rand_idx : max_idx;
        o_max_q  <= max_q;
        o_random <= explore;
      end
    end
  end

endmodule

// File: tb/tb_q_argmax_select.sv
// -----------------------------------------------------------------------------
// tb_q_argmax_select
//
// Directed and randomized bench for q_argmax_select (N = 3). Expected results
// come from a reference model that ranks values with a monotonic integer key.
// The model also advances its own copy of the LFSR once per decision.
// -----------------------------------------------------------------------------
module tb_q_argmax_select;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        i_explore_en;
  logic [15:0] i_epsilon;
  logic        o_ready;
  logic        o_valid;
  logic [1:0]  o_action;
  logic [31:0] o_max_q;
  logic        o_random;

  q_argmax_select dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .i_explore_en (i_explore_en),
    .i_epsilon    (i_epsilon),
    .o_ready      (o_ready),
    .o_valid      (o_valid),
    .o_action     (o_action),
    .o_max_q      (o_max_q),
    .o_random     (o_random)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  // Reference model state
  logic [15:0] lfsr_m;
  logic [1:0]  exp_action;
  logic [31:0] exp_max;
  logic        exp_random;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Total-order key: NaN lowest, then -Inf .. -0 == +0 .. +Inf.
  function automatic longint q_key(input logic [31:0] f);
    if (f[30:23] == 8'hFF && f[22:0] != 23'd0) return 64'sd0;
    if (f[31]) return 64'sh8000_0000 - longint'(f[30:0]);
    return 64'sh8000_0000 + longint'(f[30:0]);
  endfunction

  task automatic model_decide(input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic en, input logic [15:0] eps);
    logic [31:0] b[3];
    longint      best;
    int          r;
    b = '{b0, b1, b2};
    best       = q_key(b[0]);
    exp_action = 2'd0;
    exp_max    = b[0];
    for (int i = 1; i < 3; i++) begin
      if (q_key(b[i]) > best) begin
        best       = q_key(b[i]);
        exp_action = 2'(i);
        exp_max    = b[i];
      end
    end
    lfsr_m     = (lfsr_m >> 1) ^ (lfsr_m[0] ? 16'hB400 : 16'h0000);
    exp_random = en && (lfsr_m < eps);
    if (exp_random) begin
      r = int'(lfsr_m % 16'd4);
      if (r >= 3) r = r - 3;
      exp_action = 2'(r);
    end
  endtask

  // Drives one decision starting at a negedge in IDLE, with optional stalls
  // after beat 0 and beat 1, then checks latency, results and hold behaviour.
  task automatic do_decision(input string name, input logic [31:0] b0, input logic [31:0] b1,
                             input logic [31:0] b2, input logic en, input logic [15:0] eps,
                             input int gap0, input int gap1);
    logic [31:0] b[3];
    b = '{b0, b1, b2};
    model_decide(b0, b1, b2, en, eps);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) check({name, ".ready_idle"}, o_ready, 1);
      i_valid      = 1'b1;
      i_data       = b[i];
      // Exploration controls only matter on the last beat.
      i_explore_en = (i == 2) ? en : ~en;
      i_epsilon    = (i == 2) ? eps : ~eps;
      for (int g = 0; g < ((i == 0) ? gap0 : (i == 1) ? gap1 : 0); g++) begin
        @(negedge clk);
        i_valid = 1'b0;
        i_data  = $urandom;
      end
    end
    // DECIDE: not ready; this beat must be dropped.
    @(negedge clk);
    check({name, ".valid_decide"}, o_valid, 0);
    check({name, ".ready_decide"}, o_ready, 0);
    i_valid = 1'b1;
    i_data  = 32'h7F7F_FFFF;
    // OUT: results presented.
    @(negedge clk);
    check({name, ".valid_out"}, o_valid, 1);
    check({name, ".ready_out"}, o_ready, 0);
    check({name, ".action"}, o_action, exp_action);
    check({name, ".max_q"}, o_max_q, exp_max);
    check({name, ".random"}, o_random, exp_random);
    i_data = 32'h7F80_0000;
    // Back in IDLE: single-cycle pulse, outputs held.
    @(negedge clk);
    i_valid = 1'b0;
    check({name, ".valid_drop"}, o_valid, 0);
    check({name, ".action_hold"}, o_action, exp_action);
    check({name, ".max_hold"}, o_max_q, exp_max);
  endtask

  function automatic logic [31:0] rand_q();
    logic [31:0] pool[3];
    pool = '{32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000};
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return {$urandom_range(0, 1) == 1, 8'hFF, 23'h40_0000 | 23'($urandom)};
      3:       return 32'h7F80_0000;
      4:       return 32'hFF80_0000;
      5, 6:    return pool[$urandom_range(0, 2)];
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n        = 1'b0;
    i_valid      = 1'b0;
    i_data       = '0;
    i_explore_en = 1'b0;
    i_epsilon    = '0;
    lfsr_m       = 16'hACE1;

    repeat (2) @(negedge clk);
    check("rst.valid",  o_valid, 0);
    check("rst.action", o_action, 0);
    check("rst.max_q",  o_max_q, 0);
    check("rst.random", o_random, 0);
    check("rst.ready",  o_ready, 1);
    rst_n = 1'b1;

    // First decision after reset explores: LFSR ACE1 -> E270, index 0.
    do_decision("explore", 32'h3F80_0000, 32'h4020_0000, 32'hC040_0000, 1'b1, 16'hFFFF, 0, 0);
    check("explore.lit_random", o_random, 1);
    check("explore.lit_action", o_action, 0);
    check("explore.lit_max",    o_max_q, 32'h4020_0000);

    do_decision("eps0", 32'h3F80_0000, 32'h4020_0000, 32'hC040_0000, 1'b1, 16'h0000, 0, 0);
    check("eps0.lit_random", o_random, 0);
    check("eps0.lit_action", o_action, 1);

    do_decision("greedy", 32'h3F80_0000, 32'h4020_0000, 32'hC040_0000, 1'b0, 16'hFFFF, 0, 0);
    check("greedy.lit_action", o_action, 1);
    check("greedy.lit_max",    o_max_q, 32'h4020_0000);

    do_decision("neg", 32'hBF80_0000, 32'hBF00_0000, 32'hC000_0000, 1'b0, 16'h0000, 0, 0);
    check("neg.lit_action", o_action, 1);
    check("neg.lit_max",    o_max_q, 32'hBF00_0000);

    do_decision("zero", 32'h8000_0000, 32'h0000_0000, 32'hBF80_0000, 1'b0, 16'h0000, 0, 0);
    check("zero.lit_action", o_action, 0);
    check("zero.lit_max",    o_max_q, 32'h8000_0000);

    do_decision("tie", 32'h4000_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0, 16'h0000, 0, 0);
    check("tie.lit_action", o_action, 0);

    do_decision("allnan", 32'h7FC0_0000, 32'h7F80_0001, 32'hFFC0_0000, 1'b0, 16'h0000, 1, 0);
    check("allnan.lit_action", o_action, 0);
    check("allnan.lit_max",    o_max_q, 32'h7FC0_0000);

    do_decision("nanstall", 32'h7FC0_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0, 16'h0000, 3, 0);
    check("nanstall.lit_action", o_action, 1);
    check("nanstall.lit_max",    o_max_q, 32'h3F80_0000);

    // Reset after beat 1: partial set discarded, LFSR back to seed.
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 32'h3F80_0000;
    @(negedge clk);
    i_data  = 32'h4020_0000;
    @(negedge clk);
    i_valid = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("midrst.valid",  o_valid, 0);
    check("midrst.action", o_action, 0);
    check("midrst.max_q",  o_max_q, 0);
    check("midrst.random", o_random, 0);
    check("midrst.ready",  o_ready, 1);
    @(negedge clk);
    rst_n  = 1'b1;
    lfsr_m = 16'hACE1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst.no_valid", o_valid, 0);
    end
    do_decision("postrst", 32'h3F80_0000, 32'h4020_0000, 32'hC040_0000, 1'b1, 16'hFFFF, 0, 0);
    check("postrst.lit_random", o_random, 1);
    check("postrst.lit_action", o_action, 0);

    // Randomized decisions against the reference model.
    for (int n = 0; n < 40; n++) begin
      logic [15:0] eps;
      case ($urandom_range(0, 3))
        0:       eps = 16'hFFFF;
        1:       eps = 16'h0000;
        default: eps = 16'($urandom);
      endcase
      do_decision("rand", rand_q(), rand_q(), rand_q(), 1'($urandom_range(0, 1)), eps,
                  int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
